// File: rtl/regfile_write_queue.sv
// Register file write port queue: buffers load/ALU results in order,
// drains one per cycle, and forwards queued values to decode reads.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_valid,
  input  logic [AW-1:0]              ld_addr,
  input  logic [DW-1:0]              ld_data,
  output logic                       ld_ready,
  input  logic                       alu_valid,
  input  logic [AW-1:0]              alu_addr,
  input  logic [DW-1:0]              alu_data,
  output logic                       alu_ready,
  output logic                       WE3,
  output logic [AW-1:0]              A3,
  output logic [DW-1:0]              WD3,
  input  logic [AW-1:0]              A1,
  input  logic [AW-1:0]              A2,
  output logic                       fwd1_hit,
  output logic [DW-1:0]              fwd1_data,
  output logic                       fwd2_hit,
  output logic [DW-1:0]              fwd2_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST2 = CW'(DEPTH - 2);

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] alu_slot;
  logic [CW-1:0] count_q, count_d;
  logic          ld_push, alu_push, pop;

  assign count = count_q;

  always_comb begin
    ld_ready  = rst & (count_q < FULL);
    alu_ready = rst & ((count_q <= LAST2) |
                       ((count_q == LAST) & ~ld_valid));
    ld_push   = ld_valid & ld_ready;
    alu_push  = alu_valid & alu_ready;
    pop       = (count_q != '0);
    WE3       = pop;
    A3        = pop ? addr_q[rd_ptr_q] : '0;
    WD3       = pop ? data_q[rd_ptr_q] : '0;
  end

  // Load is older than the ALU result on a double accept.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    alu_slot = wr_ptr_q + PW'(ld_push);
    if (ld_push) begin
      addr_d[wr_ptr_q] = ld_addr;
      data_d[wr_ptr_q] = ld_data;
    end
    if (alu_push) begin
      addr_d[alu_slot] = alu_addr;
      data_d[alu_slot] = alu_data;
    end
    wr_ptr_d = wr_ptr_q + PW'(ld_push) + PW'(alu_push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(ld_push) + CW'(alu_push) - CW'(pop);
  end

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (addr_q[idx] == A1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_q[idx];
        end
        if (addr_q[idx] == A2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_q[idx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule
